// File: rtl/pdm_sample_feeder.sv
// Sample buffer and tick generator ahead of the PDM modulator: queues signed
// 8-bit samples and presents one attenuated level per sample period.
module pdm_sample_feeder #(
  parameter int TICK_DIV         = 4,
  parameter int TICKS_PER_SAMPLE = 64,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  enable_in,
  input  logic [2:0]                            vol_shift_in,
  input  logic signed [7:0]                     sample_in,
  input  logic                                  sample_valid_in,
  output logic                                  sample_ready_out,
  output logic signed [7:0]                     level_out,
  output logic                                  tick_out,
  output logic                                  sample_strobe_out,
  output logic                                  underrun_out,
  output logic [7:0]                            underrun_count_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(TICKS_PER_SAMPLE);

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]     head_reg;
  logic [PW-1:0]     tail_reg;
  logic [CW-1:0]     count_reg;
  logic [TW-1:0]     tick_cnt_reg;
  logic [SW-1:0]     samp_cnt_reg;
  logic              tick_reg;
  logic              strobe_reg;
  logic              underrun_reg;
  logic [7:0]        underrun_cnt_reg;
  logic signed [7:0] level_reg;

  logic              push;
  logic              pop;
  logic              empty;
  logic              pop_data;
  logic signed [7:0] head_sample;

  assign empty            = (count_reg == '0);
  assign sample_ready_out = !rst_in && (count_reg < CW'(FIFO_DEPTH));
  assign push             = sample_valid_in && sample_ready_out;
  // Outputs are forced low as soon as enable drops, not one edge later.
  assign tick_out         = tick_reg && enable_in;
  assign pop              = tick_out && (samp_cnt_reg == SW'(TICKS_PER_SAMPLE - 1));
  assign pop_data         = pop && !empty;
  assign head_sample      = mem[head_reg];

  assign level_out          = level_reg;
  assign sample_strobe_out  = strobe_reg && enable_in;
  assign underrun_out       = underrun_reg && enable_in;
  assign underrun_count_out = underrun_cnt_reg;
  assign fifo_count_out     = count_reg;

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[tail_reg] <= sample_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + 1'b1;
      end
      if (pop_data) begin
        head_reg <= head_reg + 1'b1;
      end
      case ({push, pop_data})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || !enable_in) begin
      tick_cnt_reg <= '0;
      tick_reg     <= 1'b0;
      samp_cnt_reg <= '0;
    end else begin
      if (tick_cnt_reg == TW'(TICK_DIV - 1)) begin
        tick_cnt_reg <= '0;
        tick_reg     <= 1'b1;
      end else begin
        tick_cnt_reg <= tick_cnt_reg + TW'(1);
        tick_reg     <= 1'b0;
      end
      if (tick_out) begin
        samp_cnt_reg <= pop ? '0 : samp_cnt_reg + SW'(1);
      end
    end
  end

  // The level is reloaded on the last tick of a period so it is stable before
  // the first tick of the next one.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      level_reg        <= '0;
      strobe_reg       <= 1'b0;
      underrun_reg     <= 1'b0;
      underrun_cnt_reg <= '0;
    end else if (!enable_in) begin
      level_reg    <= '0;
      strobe_reg   <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      strobe_reg   <= pop;
      underrun_reg <= pop && empty;
      if (pop) begin
        if (empty) begin
          level_reg <= '0;
          if (underrun_cnt_reg != 8'hFF) begin
            underrun_cnt_reg <= underrun_cnt_reg + 8'd1;
          end
        end else begin
          level_reg <= head_sample >>> vol_shift_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_sample_feeder.sv
// Randomised and directed checks of pdm_sample_feeder against an elapsed-cycle
// and queue based model of the feeder.
module tb_pdm_sample_feeder;

  localparam int TD    = 4;
  localparam int TPS   = 4;
  localparam int DEPTH = 4;
  localparam int PER   = TD * TPS;

  logic              clk = 1'b0;
  logic              rst_in = 1'b1;
  logic              enable_in = 1'b0;
  logic [2:0]        vol_shift_in = 3'd0;
  logic signed [7:0] sample_in = 8'sd0;
  logic              sample_valid_in = 1'b0;
  logic              sample_ready_out;
  logic signed [7:0] level_out;
  logic              tick_out;
  logic              sample_strobe_out;
  logic              underrun_out;
  logic [7:0]        underrun_count_out;
  logic [2:0]        fifo_count_out;

  pdm_sample_feeder #(
    .TICK_DIV(TD), .TICKS_PER_SAMPLE(TPS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .enable_in(enable_in),
    .vol_shift_in(vol_shift_in), .sample_in(sample_in),
    .sample_valid_in(sample_valid_in), .sample_ready_out(sample_ready_out),
    .level_out(level_out), .tick_out(tick_out),
    .sample_strobe_out(sample_strobe_out), .underrun_out(underrun_out),
    .underrun_count_out(underrun_count_out), .fifo_count_out(fifo_count_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sample queue plus the number of consecutive enabled edges since
  // the last reset/disable. Ticks fall on every TD-th enabled edge and the
  // period ends on every PER-th.
  int  q[$];
  int  run = 0;
  int  m_level = 0;
  bit  m_strobe = 0;
  bit  m_under = 0;
  int  m_ucnt = 0;
  bit  m_valid = 0;

  always @(posedge clk) begin
    bit pop, push;
    if (rst_in) begin
      q.delete();
      run = 0; m_level = 0; m_strobe = 0; m_under = 0; m_ucnt = 0;
      m_valid = 1;
    end else begin
      pop  = enable_in && run > 0 && (run % PER) == 0;
      push = sample_valid_in && q.size() < DEPTH;
      if (!enable_in) begin
        m_level = 0; m_strobe = 0; m_under = 0;
      end else begin
        m_strobe = pop;
        m_under  = pop && q.size() == 0;
        if (pop) begin
          if (q.size() > 0) begin
            m_level = q.pop_front() >>> vol_shift_in;
          end else begin
            m_level = 0;
            if (m_ucnt < 255) m_ucnt++;
          end
        end
      end
      if (push) q.push_back(int'(sample_in));
      run = enable_in ? run + 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ready", int'(sample_ready_out), int'(!rst_in && q.size() < DEPTH));
      check("tick", int'(tick_out), int'(enable_in && run > 0 && (run % TD) == 0));
      check("strobe", int'(sample_strobe_out), int'(enable_in && m_strobe));
      check("underrun", int'(underrun_out), int'(enable_in && m_under));
      check("level", int'(level_out), m_level);
      check("ucount", int'(underrun_count_out), m_ucnt);
      check("count", int'(fifo_count_out), q.size());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Waits (bounded) for a strobe; reports cycles waited and ticks seen.
  task automatic wait_strobe(string tag, output int n, output int ticks);
    n = 0;
    ticks = 0;
    do begin
      cyc();
      n++;
      if (tick_out) ticks++;
    end while (!sample_strobe_out && n < 60);
    if (!sample_strobe_out) begin
      tests++;
      fails++;
      $display("FAIL %s: no sample_strobe_out within %0d cycles", tag, n);
    end
  endtask

  task automatic push_one(logic signed [7:0] v);
    sample_in = v;
    sample_valid_in = 1'b1;
    cyc();
    sample_valid_in = 1'b0;
  endtask

  initial begin
    int n, tk, cnt;
    int exp_play[4];
    exp_play = '{10, -20, 127, -128};

    // Reset and idle
    rst_in = 1'b1;
    repeat (3) begin
      cyc();
      check("ready_in_reset", int'(sample_ready_out), 0);
      check("level_in_reset", int'(level_out), 0);
    end
    rst_in = 1'b0;
    #1;
    check("ready_after_reset", int'(sample_ready_out), 1);
    cnt = 0;
    repeat (50) begin
      cyc();
      if (tick_out) cnt++;
    end
    check("idle_ticks", cnt, 0);

    // Playback and tick cadence
    foreach (exp_play[i]) push_one(8'(exp_play[i]));
    check("queued_4", int'(fifo_count_out), 4);
    enable_in = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!tick_out && n < 20);
    check("first_tick_delay", n, 4);
    for (int i = 0; i < 4; i++) begin
      wait_strobe("play", n, tk);
      check("play_level", int'(level_out), exp_play[i]);
      check("play_count", int'(fifo_count_out), 3 - i);
      if (i > 0) begin
        check("strobe_period", n, PER);
        check("ticks_per_level", tk, TPS);
      end
    end
    check("play_no_underrun", int'(underrun_count_out), 0);

    // Underrun and saturation
    for (int i = 0; i < 3; i++) begin
      wait_strobe("under", n, tk);
      check("under_pulse", int'(underrun_out), 1);
      check("under_level", int'(level_out), 0);
    end
    check("under_count_3", int'(underrun_count_out), 3);
    repeat (300 * PER) cyc();
    check("under_saturate", int'(underrun_count_out), 255);

    // Full FIFO and back-pressure
    enable_in = 1'b0;
    sample_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample_in = 8'(i + 1);
      cyc();
    end
    sample_valid_in = 1'b0;
    check("full_count", int'(fifo_count_out), 4);
    check("full_ready", int'(sample_ready_out), 0);
    enable_in = 1'b1;
    wait_strobe("refill", n, tk);
    check("ready_after_pop", int'(sample_ready_out), 1);
    check("level_first_of_full", int'(level_out), 1);
    for (int i = 0; i < 3; i++) wait_strobe("drain", n, tk);
    check("drained_level", int'(level_out), 4);
    // Push on an empty FIFO in the very cycle of the next pop.
    repeat (PER - 1) cyc();
    sample_in = 8'sd55;
    sample_valid_in = 1'b1;
    cyc();
    sample_valid_in = 1'b0;
    check("same_cycle_underrun", int'(underrun_out), 1);
    check("same_cycle_count", int'(fifo_count_out), 1);

    // Arithmetic shift
    rst_in = 1'b1;
    cyc();
    rst_in = 1'b0;
    enable_in = 1'b0;
    vol_shift_in = 3'd7;
    push_one(-8'sd128);
    push_one(8'sd127);
    enable_in = 1'b1;
    wait_strobe("shift_a", n, tk);
    check("shift7_neg", int'(level_out), -1);
    wait_strobe("shift_b", n, tk);
    check("shift7_pos", int'(level_out), 0);
    vol_shift_in = 3'd2;
    push_one(-8'sd100);
    vol_shift_in = 3'd2;
    wait_strobe("shift_c", n, tk);
    check("shift2", int'(level_out), -25);
    vol_shift_in = 3'd5;
    repeat (6) cyc();
    check("hold_after_vol_change", int'(level_out), -25);

    // Mid-period reset with samples queued
    push_one(8'sd11);
    push_one(8'sd22);
    push_one(8'sd33);
    repeat (3) cyc();
    rst_in = 1'b1;
    cyc();
    check("rst_count", int'(fifo_count_out), 0);
    check("rst_level", int'(level_out), 0);
    rst_in = 1'b0;
    vol_shift_in = 3'd0;
    push_one(8'sd77);
    wait_strobe("resume", n, tk);
    check("resume_level", int'(level_out), 77);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      sample_valid_in = ($urandom_range(0, 3) == 0);
      sample_in = 8'($urandom);
      if ($urandom_range(0, 40) == 0) vol_shift_in = 3'($urandom);
      if ($urandom_range(0, 150) == 0) enable_in = ($urandom_range(0, 3) != 0);
      rst_in = ($urandom_range(0, 700) == 0);
      cyc();
    end
    rst_in = 1'b0;
    sample_valid_in = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
